// File: rtl/packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : packet_arbiter
// Purpose  : Packet-granular round-robin merge of NUM_SRC sources onto one
//            registered packet bus. Optional counters: PKT_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module packet_arbiter #(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = 64,
    localparam int BE_W    = DATA_W / 8,
    localparam int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        in_valid,
    input  logic [NUM_SRC*DATA_W-1:0] in_data,
    input  logic [NUM_SRC*BE_W-1:0]   in_byte_enable,
    input  logic [NUM_SRC-1:0]        in_sop,
    input  logic [NUM_SRC-1:0]        in_eop,
    output logic [NUM_SRC-1:0]        in_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [BE_W-1:0]           out_byte_enable,
    output logic                      out_sop,
    output logic                      out_eop,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      err_orphan
`ifdef PKT_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]     pkt_count,
    output logic [15:0]               orphan_count
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_last_grant, w_last_grant_nxt;
    logic [ID_W-1:0]     r_grant_id, w_grant_nxt;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [BE_W-1:0]     r_out_be;
    logic                r_out_sop;
    logic                r_out_eop;

    logic [NUM_SRC-1:0]  w_req;
    logic [ID_W-1:0]     w_cand;
    logic [ID_W-1:0]     w_winner;
    logic                w_found;
    logic                w_load;
    logic                w_accept;
    logic                w_orphan;
    logic [NUM_SRC-1:0]  w_in_ready;
    logic                w_sel_valid;
    logic [DATA_W-1:0]   w_sel_data;
    logic [BE_W-1:0]     w_sel_be;
    logic                w_sel_sop;
    logic                w_sel_eop;

    assign w_req  = in_valid & in_sop;
    assign w_load = out_ready || !r_out_valid;

    // Round-robin search starting just after the last source that finished.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = ID_W'((int'(r_last_grant) + k) % NUM_SRC);
            if (!w_found && w_req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_be    = '0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ID_W'(i) == r_grant_id) begin
                w_sel_valid = in_valid[i];
                w_sel_data  = in_data[i*DATA_W +: DATA_W];
                w_sel_be    = in_byte_enable[i*BE_W +: BE_W];
                w_sel_sop   = in_sop[i];
                w_sel_eop   = in_eop[i];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_in_ready       = '0;
        w_accept         = 1'b0;
        w_orphan         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Non-sop beats seen between packets are drained and flagged.
                w_in_ready = in_valid & ~in_sop;
                w_orphan   = |w_in_ready;
                if (w_found) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (ID_W'(i) == r_grant_id) begin
                        w_in_ready[i] = w_load;
                    end
                end
                w_accept = w_sel_valid && w_load;
                if (w_accept && w_sel_eop) begin
                    w_last_grant_nxt = r_grant_id;
                    w_state_nxt      = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= ID_W'(NUM_SRC - 1);
            r_grant_id   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_be     <= '0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_grant_id   <= w_grant_nxt;
            if (w_load) begin
                r_out_valid <= w_accept;
                r_out_data  <= w_accept ? w_sel_data : '0;
                r_out_be    <= w_accept ? w_sel_be   : '0;
                r_out_sop   <= w_accept && w_sel_sop;
                r_out_eop   <= w_accept && w_sel_eop;
            end
        end
    end

    // Handshake outputs stay quiet while reset is held.
    assign in_ready        = w_in_ready & {NUM_SRC{rst_n}};
    assign err_orphan      = w_orphan & rst_n;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign out_byte_enable = r_out_be;
    assign out_sop         = r_out_sop;
    assign out_eop         = r_out_eop;
    assign grant_id        = r_grant_id;
    assign busy            = (r_state == S_XFER);

`ifdef PKT_ARB_STATS_EN
    logic [15:0] r_orphan_cnt;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_pkt_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept && w_sel_eop && (r_grant_id == ID_W'(g))) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign pkt_count[g*16 +: 16] = r_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orphan_cnt <= '0;
        end else if (w_orphan && (r_orphan_cnt != 16'hFFFF)) begin
            r_orphan_cnt <= r_orphan_cnt + 16'd1;
        end
    end
    assign orphan_count = r_orphan_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_arbiter
// Purpose  : Scoreboard bench for packet_arbiter with a packet-level
//            round-robin reference model.
// Revision : 1.0
// ============================================================================
module tb_packet_arbiter;
    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 64;
    localparam int BE_W    = 8;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  be;
        logic        sop;
        logic        eop;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_SRC-1:0]        in_valid = '0;
    logic [NUM_SRC*DATA_W-1:0] in_data = '0;
    logic [NUM_SRC*BE_W-1:0]   in_byte_enable = '0;
    logic [NUM_SRC-1:0]        in_sop = '0;
    logic [NUM_SRC-1:0]        in_eop = '0;
    logic [NUM_SRC-1:0]        in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [BE_W-1:0]           out_byte_enable;
    logic                      out_sop;
    logic                      out_eop;
    logic                      out_ready = 1'b1;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      err_orphan;
`ifdef PKT_ARB_STATS_EN
    logic [NUM_SRC*16-1:0]     pkt_count;
    logic [15:0]               orphan_count;
`endif

    packet_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_byte_enable(in_byte_enable),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_byte_enable(out_byte_enable),
        .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .err_orphan(err_orphan)
`ifdef PKT_ARB_STATS_EN
        , .pkt_count(pkt_count), .orphan_count(orphan_count)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc_cnt  = 0;
    int           model_last = NUM_SRC - 1;
    beat_t        src_q[NUM_SRC][$];
    beat_t        expq[$];
    int           vlog[$];
    bit           log_en = 1'b0;
    logic [NUM_SRC-1:0] acc = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: acceptance bookkeeping and scoreboard comparison, pre-edge.
    always @(negedge clk) begin
        beat_t e;
        acc = in_valid & in_ready;
        if (rst_n) begin
            if (log_en && out_valid) vlog.push_back(cyc_cnt);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {out_data, out_sop, out_eop}, 0);
                end else begin
                    e = expq.pop_front();
                    chk("beat", {out_data, out_byte_enable, out_sop, out_eop},
                        {e.d, e.be, e.sop, e.eop});
                end
            end
        end
    end

    // Packet of nbytes, byte 0 in the MSBs, MSB-aligned enables on the last beat.
    task automatic add_packet(input int s, input int nbytes, input bit seq);
        int nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t bt;
            logic [7:0] bv;
            bt = '0;
            for (int k = 0; k < 8; k++) begin
                int idx = b * 8 + k;
                if (idx < nbytes) begin
                    bv = seq ? 8'(idx) : 8'($urandom);
                    bt.d[63-8*k -: 8] = bv;
                    bt.be[7-k] = 1'b1;
                end
            end
            bt.sop = (b == 0);
            bt.eop = (b == nb - 1);
            src_q[s].push_back(bt);
        end
    endtask

    // Every source with packets pending always requests, so the merged order is
    // plain round-robin over the non-empty source lists.
    task automatic build_expected();
        beat_t cp[NUM_SRC][$];
        int    win;
        beat_t b;
        for (int s = 0; s < NUM_SRC; s++) cp[s] = src_q[s];
        forever begin
            win = -1;
            for (int k = 1; k <= NUM_SRC; k++) begin
                int s = (model_last + k) % NUM_SRC;
                if (win < 0 && cp[s].size() > 0) win = s;
            end
            if (win < 0) break;
            do begin
                b = cp[win].pop_front();
                expq.push_back(b);
            end while (!b.eop);
            model_last = win;
        end
    endtask

    task automatic drive_idle();
        in_valid = '0; in_sop = '0; in_eop = '0;
        in_data = '0; in_byte_enable = '0;
        out_ready = 1'b1;
    endtask

    task automatic drive_src(input int s, input beat_t b, input logic v);
        in_valid[s] = v;
        in_sop[s]   = b.sop;
        in_eop[s]   = b.eop;
        in_data[s*DATA_W +: DATA_W]      = b.d;
        in_byte_enable[s*BE_W +: BE_W]   = b.be;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        expq.delete();
        for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_last = NUM_SRC - 1;
    endtask

    // mode 0: out_ready high, 1: random back-pressure, 2: 5-cycle stall window
    task automatic run_traffic(input int mode);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            #2;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (src_q[s].size() > 0)
                    drive_src(s, src_q[s][0], src_q[s][0].sop ? 1'b1 : ($urandom_range(3) != 0));
                else
                    drive_src(s, '0, 1'b0);
            end
            case (mode)
                1:       out_ready = ($urandom_range(2) != 0);
                2:       out_ready = !(cyc >= 5 && cyc < 10);
                default: out_ready = 1'b1;
            endcase
            cyc++;
            done = (expq.size() == 0);
            for (int s = 0; s < NUM_SRC; s++) if (src_q[s].size() > 0) done = 1'b0;
        end
        chk("traffic_timeout", done, 1'b1);
        @(posedge clk);
        #2 drive_idle();
    endtask

    initial begin
        // Reset state, with an orphan-looking beat held on source 1.
        in_valid = 4'b0010;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_grant_busy", {grant_id, busy}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_err_orphan", err_orphan, 0);
        do_reset();

        // Single 20-byte packet on source 2.
        add_packet(2, 20, 1'b1);
        build_expected();
        fork
            run_traffic(0);
            begin
                int n = 0;
                while (!in_valid[2] && n < 20) begin @(negedge clk); n++; end
                @(posedge clk);
                #1 chk("t1_grant", {grant_id, busy}, {2'd2, 1'b1});
                n = 0;
                do begin @(negedge clk); n++; end while (!(out_valid && out_sop) && n < 50);
                chk("t1_first_data", out_data, 64'h0001020304050607);
                n = 0;
                do begin @(negedge clk); n++; end while (!(out_valid && out_eop) && n < 50);
                chk("t1_last_be", out_byte_enable, 8'hF0);
                chk("t1_busy_drop", busy, 0);
            end
        join

        // All four sources with 1-beat packets from reset.
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) add_packet(s, 8, 1'b0);
        add_packet(0, 8, 1'b0);
        build_expected();
        vlog.delete();
        log_en = 1'b1;
        run_traffic(0);
        log_en = 1'b0;
        chk("t2_beats", vlog.size(), 5);
        for (int i = 1; i < vlog.size(); i++) chk("t2_spacing", vlog[i] - vlog[i-1], 2);

        // Five-cycle stall in the middle of a 64-byte packet.
        add_packet(0, 64, 1'b0);
        build_expected();
        fork
            run_traffic(2);
            begin
                logic [127:0] prev = '0;
                logic [127:0] cur;
                bit prev_st = 1'b0;
                bit st;
                int nst = 0;
                repeat (40) begin
                    @(negedge clk);
                    cur = {out_valid, out_sop, out_eop, out_byte_enable, out_data};
                    st  = out_valid && !out_ready;
                    if (st) begin
                        nst++;
                        chk("t3_in_ready_low", in_ready, 0);
                    end
                    if (st && prev_st) chk("t3_hold", cur, prev);
                    prev = cur;
                    prev_st = st;
                end
                chk("t3_stall_cycles", nst, 5);
            end
        join

        // Random packets with random back-pressure.
        for (int p = 0; p < 14; p++) add_packet($urandom_range(NUM_SRC-1), $urandom_range(40, 1), 1'b0);
        build_expected();
        run_traffic(1);

        // Orphan beat on source 1 while idle.
        @(posedge clk);
        #2 drive_src(1, {64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, 1'b0}, 1'b1);
        @(negedge clk);
        chk("t4_orphan_ready", in_ready, 4'b0010);
        chk("t4_orphan_pulse", err_orphan, 1);
        @(posedge clk);
        #2 drive_idle();
        @(negedge clk);
        chk("t4_orphan_end", err_orphan, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_output", out_valid, 0);
        end

        // Reset on the second beat of a 3-beat packet.
        add_packet(2, 24, 1'b0);
        build_expected();
        @(posedge clk); #2 drive_src(2, src_q[2][0], 1'b1);
        @(posedge clk);
        @(posedge clk); #2 drive_src(2, src_q[2][1], 1'b1);
        @(posedge clk); #2 drive_src(2, src_q[2][2], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_out_zero", {out_valid, out_sop, out_eop, out_byte_enable, out_data}, 0);
        chk("t5_ctrl_zero", {grant_id, busy, in_ready, err_orphan}, 0);
        do_reset();
        add_packet(3, 24, 1'b0);
        add_packet(0, 8, 1'b0);
        chk("t5_first_src0", src_q[0][0].eop, 1);
        build_expected();
        run_traffic(0);

`ifdef PKT_ARB_STATS_EN
        do_reset();
        for (int p = 0; p < 3; p++) add_packet(0, $urandom_range(24, 1), 1'b0);
        add_packet(3, 16, 1'b0);
        build_expected();
        run_traffic(1);
        chk("stats_pkt_count", pkt_count, {16'd1, 16'd0, 16'd0, 16'd3});
        chk("stats_orphan", orphan_count, 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/packet_arbiter.md
Name: packet_arbiter

Overview:
- Merges NUM_SRC packet sources onto one 64-bit packet bus carrying valid, data, byte_enable, sop and eop.
- Arbitration is round-robin at packet granularity. Once a source is granted, it holds the bus from its sop beat to its eop beat.
- Adds per-source ready back-pressure and a registered output stage.
- Sits between the packet generators/ingress ports and the single dissector datapath.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_W, 64, data width in bits (multiple of 8).
- BE_W, DATA_W/8, byte-enable width; derived, not overridden.
- ID_W, $clog2(NUM_SRC), grant index width; derived.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_SRC  per-source beat valid.
- in_data  in  NUM_SRC*DATA_W  per-source data; source i at [i*DATA_W +: DATA_W]; byte 0 in MSBs.
- in_byte_enable  in  NUM_SRC*BE_W  per-source byte enables; MSB-aligned on the last beat.
- in_sop  in  NUM_SRC  per-source start of packet.
- in_eop  in  NUM_SRC  per-source end of packet.
- in_ready  out  NUM_SRC  per-source accept.
- out_valid  out  1  merged beat valid.
- out_data  out  DATA_W  merged data.
- out_byte_enable  out  BE_W  merged byte enables.
- out_sop  out  1  merged start of packet.
- out_eop  out  1  merged end of packet.
- out_ready  in  1  downstream accept.
- grant_id  out  ID_W  currently/last granted source.
- busy  out  1  high while in XFER.
- err_orphan  out  1  one-cycle pulse; a non-sop beat was discarded in IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs 0.
  - State IDLE.
  - last_grant = NUM_SRC-1, so source 0 wins first.
  - A reset mid-packet drops the packet; no eop is emitted.
- Beat transfer:
  - Input beat accepted when in_valid[i] && in_ready[i].
  - Output beat consumed when out_valid && out_ready.
- Output register:
  - Loads whenever out_ready || !out_valid.
  - On load with an accepted beat: captures data/byte_enable/sop/eop, out_valid=1.
  - On load with no accepted beat: out_valid=0 and data/byte_enable/sop/eop cleared to 0.
  - While stalled (out_valid && !out_ready), all out_* hold.
  - Latency: accepted beat appears on out_* the next cycle.
- FSM state IDLE:
  - req[i] = in_valid[i] && in_sop[i].
  - Winner = first set req scanning last_grant+1, +2, … modulo NUM_SRC.
  - If any req: grant_id<=winner, state<=XFER. No beat is accepted in the IDLE cycle.
  - in_ready[i] = in_valid[i] && !in_sop[i] (orphan discard).
  - Any orphan discard: err_orphan=1 for that cycle.
- FSM state XFER:
  - busy=1.
  - in_ready[grant_id] = out_ready || !out_valid; all other in_ready=0.
  - Accepted beat with in_eop (including a single-beat sop&eop packet): last_grant<=grant_id, state<=IDLE.
  - A sop on the granted source before eop is forwarded unchanged; the arbiter does not police it.
- Packet spacing: minimum one idle cycle on out_valid between packets from different or the same sources, used for arbitration.
- Fairness: a source waiting with sop is granted within NUM_SRC-1 packets of other sources.
- Inputs of non-granted sources are never consumed in XFER and must be held by the source.
- byte_enable passes through unmodified.

Optional Feature:
- Macro: PKT_ARB_STATS_EN.
- With PKT_ARB_STATS_EN:
  - Adds output pkt_count [NUM_SRC*16]: per-source 16-bit count of eop beats accepted, wrapping at 65535->0.
  - Adds output orphan_count [16]: saturates at 65535.
  - All counters reset to 0.
- Without PKT_ARB_STATS_EN: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single source, 20-byte packet (bytes 0x00..0x13) on source 2, out_ready=1:
  - Grant_id=2 one cycle after sop presented.
  - 3 output beats; first out_data=0x0001020304050607 with sop.
  - Last beat byte_enable=0xF0 with eop.
  - busy drops after eop.
- All 4 sources request with 1-beat packets from reset:
  - Output order 0,1,2,3,0.
  - Each packet separated by exactly one idle cycle.
- Back-pressure: out_ready low 5 cycles mid-packet:
  - out_* hold stable.
  - in_ready[grant] low after the register fills.
  - No beat lost or duplicated; data matches input sequence.
- Orphan: source 1 presents valid=1, sop=0 in IDLE:
  - in_ready[1]=1, err_orphan pulses 1 cycle, nothing on out.
- Reset asserted on the 2nd beat of a 3-beat packet:
  - All outputs 0 immediately.
  - After release, source 0 is granted first; no stray eop.
- With PKT_ARB_STATS_EN, after sending 3 packets on source 0 and 1 on source 3:
  - pkt_count source 0 = 3, source 3 = 1, others 0.
